// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues variable-latency imem requests and holds the
// IF/ID pipeline register, with hazard stalls and ID-resolved redirects (one delay slot).
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc8
);

  localparam logic [0:0] StFetch = 1'b0;
  localparam logic [0:0] StHold  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc8_q, id_pc8_d;

  logic        accept;
  logic        redir_take;
  logic [31:0] redir_addr;
  logic [31:0] next_pc;
  logic        deliver;
  logic [31:0] deliver_instr;

  assign accept     = ~stall_i;
  assign redir_take = redirect_i & accept;
  assign redir_addr = {redirect_pc_i[31:2], 2'b00};

  // A redirect seen on the delivery edge bypasses the pending slot and steers pc_q directly.
  assign next_pc = redir_take   ? redir_addr :
                   redir_pend_q ? redir_tgt_q :
                                  pc_q + 32'd4;

  assign imem_req  = (state_q == StFetch);
  assign imem_addr = pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redir_pend_d  = redir_pend_q;
    redir_tgt_d   = redir_tgt_q;
    hold_buf_d    = hold_buf_q;
    valid_d       = valid_q;
    instr_d       = instr_q;
    id_pc_d       = id_pc_q;
    id_pc8_d      = id_pc8_q;
    deliver       = 1'b0;
    deliver_instr = hold_buf_q;

    case (state_q)
      StFetch: begin
        if (imem_ack) begin
          if (accept) begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
          end else begin
            hold_buf_d = imem_rdata;
            state_d    = StHold;
          end
        end else if (accept) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      StHold: begin
        if (accept) begin
          deliver = 1'b1;
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase

    // The delay slot is always the word at pc_q; delivering it consumes any pending redirect.
    if (deliver) begin
      valid_d      = 1'b1;
      instr_d      = deliver_instr;
      id_pc_d      = pc_q;
      id_pc8_d     = pc_q + 32'd8;
      pc_d         = next_pc;
      redir_pend_d = 1'b0;
    end else if (redir_take) begin
      redir_pend_d = 1'b1;
      redir_tgt_d  = redir_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= 32'h0;
      hold_buf_q   <= NOP_INSTR;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      id_pc_q      <= 32'h0;
      id_pc8_q     <= 32'h8;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
      hold_buf_q   <= hold_buf_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      id_pc_q      <= id_pc_d;
      id_pc8_q     <= id_pc8_d;
    end
  end

  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = id_pc_q;
  assign if_id_pc8   = id_pc8_q;

endmodule
